// File: rtl/cdr_tx_pattern_gen.sv
// Symbol-rate pattern source for the CDR receive path: NCO symbol timing,
// 1010 preamble then PRBS7 payload, mapped to a signed 8-bit sample with one post-cursor tap.
module cdr_tx_pattern_gen #(
  parameter int unsigned     PHASE_BITS   = 32,
  parameter longint unsigned FCW_DEFAULT  = 85_899_345,
  parameter int unsigned     PREAMBLE_LEN = 16,
  parameter int unsigned     AMP          = 64,
  parameter int unsigned     ISI_SHIFT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] fcw_trim,
  input  logic [15:0] payload_len,
  output logic        sym_strobe,
  output logic        sym_bit,
  output logic [7:0]  y_n,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SAMP_W = 10;

  localparam logic [PHASE_BITS-1:0]    FCW_NOM  = PHASE_BITS'(FCW_DEFAULT);
  localparam logic signed [SAMP_W-1:0] MAIN_AMP = SAMP_W'(AMP);
  localparam logic signed [SAMP_W-1:0] POST_AMP = MAIN_AMP >>> ISI_SHIFT;
  localparam logic signed [SAMP_W-1:0] SAT_HI   = SAMP_W'(127);
  localparam logic signed [SAMP_W-1:0] SAT_LO   = -SAMP_W'(128);
  localparam logic [CNT_W-1:0]         PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PHASE_BITS-1:0]   phase_q, phase_d;
  logic [6:0]              lfsr_q, lfsr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic                    prev_valid_q, prev_valid_d;
  logic                    prev_bit_q, prev_bit_d;
  logic                    sym_bit_q, sym_bit_d;
  logic [7:0]              y_q, y_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [PHASE_BITS-1:0]   fcw_eff;
  logic [PHASE_BITS-1:0]   phase_sum;
  logic                    carry;
  logic                    prbs_fb;
  logic                    emit;
  logic                    emit_bit;

  // Main cursor plus post-cursor tap, saturated to the signed 8-bit range.
  function automatic logic [7:0] map_sample(input logic b, input logic pv, input logic pb);
    logic signed [SAMP_W-1:0] main_s;
    logic signed [SAMP_W-1:0] post_s;
    logic signed [SAMP_W-1:0] sum_s;
    main_s = b ? MAIN_AMP : -MAIN_AMP;
    post_s = '0;
    if (pv) post_s = pb ? POST_AMP : -POST_AMP;
    sum_s = main_s + post_s;
    if (sum_s > SAT_HI)      return 8'h7F;
    else if (sum_s < SAT_LO) return 8'h80;
    else                     return sum_s[7:0];
  endfunction

  // Trim is sign-extended before the add; the sum wraps modulo 2^PHASE_BITS.
  assign fcw_eff            = FCW_NOM + PHASE_BITS'($signed(fcw_trim));
  assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, fcw_eff};
  assign prbs_fb            = lfsr_q[6] ^ lfsr_q[5];
  assign sym_strobe         = en & carry & (state_q != IDLE);

  assign state   = state_q;
  assign sym_bit = sym_bit_q;
  assign y_n     = y_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      lfsr_q       <= 7'h7F;
      cnt_q        <= '0;
      len_q        <= '0;
      prev_valid_q <= 1'b0;
      prev_bit_q   <= 1'b0;
      sym_bit_q    <= 1'b0;
      y_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (en) begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      prev_valid_q <= prev_valid_d;
      prev_bit_q   <= prev_bit_d;
      sym_bit_q    <= sym_bit_d;
      y_q          <= y_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    prev_valid_d = prev_valid_q;
    prev_bit_d   = prev_bit_q;
    sym_bit_d    = sym_bit_q;
    y_d          = y_q;
    done_d       = 1'b0;
    emit         = 1'b0;
    emit_bit     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          phase_d      = '0;
          cnt_d        = '0;
          prev_valid_d = 1'b0;
          len_d        = payload_len;
          state_d      = PREAMBLE;
        end
      end
      PREAMBLE: begin
        phase_d = phase_sum;
        if (carry) begin
          emit     = 1'b1;
          emit_bit = ~cnt_q[0];
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = PAYLOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PAYLOAD: begin
        phase_d = phase_sum;
        if (carry) begin
          // Terminating strobe: the last payload symbol has now lasted a full period.
          if ((len_q != '0) && (cnt_q == len_q)) begin
            y_d       = '0;
            sym_bit_d = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            emit     = 1'b1;
            emit_bit = prbs_fb;
            lfsr_d   = {lfsr_q[5:0], prbs_fb};
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      sym_bit_d    = emit_bit;
      y_d          = map_sample(emit_bit, prev_valid_q, prev_bit_q);
      prev_bit_d   = emit_bit;
      prev_valid_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_cdr_tx_pattern_gen.sv
// Bench for cdr_tx_pattern_gen: a nominal instance and a fast, saturating instance
// share stimulus and are each compared every cycle against a symbol-level model.
module tb_cdr_tx_pattern_gen;

  localparam longint unsigned TWO32 = 64'h1_0000_0000;
  localparam longint unsigned FCW_A = 85_899_345;
  localparam longint unsigned FCW_B = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, en, start;
  logic [15:0] fcw_trim, payload_len;

  logic        sym_strobe_a, sym_bit_a, busy_a, done_a;
  logic [7:0]  y_n_a;
  logic [1:0]  state_a;
  logic        sym_strobe_b, sym_bit_b, busy_b, done_b;
  logic [7:0]  y_n_b;
  logic [1:0]  state_b;

  cdr_tx_pattern_gen dut_a (
    .clk(clk), .rst(rst), .en(en), .start(start), .fcw_trim(fcw_trim),
    .payload_len(payload_len), .sym_strobe(sym_strobe_a), .sym_bit(sym_bit_a),
    .y_n(y_n_a), .busy(busy_a), .done(done_a), .state(state_a)
  );

  cdr_tx_pattern_gen #(
    .FCW_DEFAULT(FCW_B), .PREAMBLE_LEN(4), .AMP(120), .ISI_SHIFT(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .start(start), .fcw_trim(fcw_trim),
    .payload_len(payload_len), .sym_strobe(sym_strobe_b), .sym_bit(sym_bit_b),
    .y_n(y_n_b), .busy(busy_b), .done(done_b), .state(state_b)
  );

  always #10 clk = ~clk;

  typedef struct {
    longint unsigned fcw;
    int              pre;
    int              amp;
    int              h1;
  } prm_t;

  // Model works in symbols: n counts symbols emitted this burst, pidx indexes the PRBS stream.
  typedef struct {
    bit              active;
    int              n;
    int              len;
    longint unsigned acc;
    int              pidx;
    bit              pv;
    bit              pb;
    bit              sb;
    bit              done;
    int              y;
  } mdl_t;

  typedef struct {
    bit start;
    int gap;
    int y;
    bit b;
    int st;
    bit dn;
  } vec_t;

  prm_t  pa, pbp;
  mdl_t  ma, mb;
  bit    prbs[127];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    stb_cnt_a = 0;
  bit    last_stb_a;
  bit    collect = 1'b0;
  int    bq[$];
  bit    saw_hi = 1'b0;
  bit    saw_lo = 1'b0;

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic void mstep(inout mdl_t m, input prm_t p, input bit r, input bit e,
                                input bit s, input logic [15:0] tr, input logic [15:0] ln,
                                output bit stb);
    longint unsigned f;
    bit              b;
    int              y;
    stb = 1'b0;
    if (r) begin
      m = '{default: 0};
      return;
    end
    if (!e) return;
    m.done = 1'b0;
    if (!m.active) begin
      if (s) begin
        m.active = 1'b1; m.acc = 0; m.n = 0; m.len = int'(ln); m.pv = 1'b0;
      end
      return;
    end
    f = (p.fcw + longint'($signed(tr))) & 64'hFFFF_FFFF;
    m.acc += f;
    if (m.acc < TWO32) return;
    m.acc -= TWO32;
    stb = 1'b1;
    if (m.n >= p.pre && m.len != 0 && (m.n - p.pre) == m.len) begin
      m.y = 0; m.sb = 1'b0; m.done = 1'b1; m.active = 1'b0;
      return;
    end
    if (m.n < p.pre) b = (m.n % 2 == 0);
    else begin
      b = prbs[m.pidx % 127];
      m.pidx++;
    end
    y = (b ? p.amp : -p.amp) + (m.pv ? (m.pb ? p.h1 : -p.h1) : 0);
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    m.y = y; m.sb = b; m.pb = b; m.pv = 1'b1; m.n++;
  endfunction

  function automatic int exp_state(input mdl_t m, input prm_t p);
    if (!m.active) return 0;
    return (m.n < p.pre) ? 1 : 2;
  endfunction

  task automatic chk_dut(input string t, input mdl_t m, input prm_t p, input logic [1:0] st,
                         input logic bz, input logic dn, input logic sb, input logic [7:0] y);
    chk({t, "_state"}, int'(st), exp_state(m, p));
    chk({t, "_busy"}, int'(bz), int'(m.active));
    chk({t, "_done"}, int'(dn), int'(m.done));
    chk({t, "_sym_bit"}, int'(sb), int'(m.sb));
    chk({t, "_y_n"}, int'($signed(y)), m.y);
  endtask

  // One clock: strobe checked mid-low-phase, registered outputs checked just after the edge.
  task automatic tick();
    bit       ea, eb, sb_stb;
    bit [1:0] pre_b;
    mstep(ma, pa, rst, en, start, fcw_trim, payload_len, ea);
    mstep(mb, pbp, rst, en, start, fcw_trim, payload_len, eb);
    #1;
    if (!rst) begin
      chk("a_sym_strobe", int'(sym_strobe_a), int'(ea));
      chk("b_sym_strobe", int'(sym_strobe_b), int'(eb));
    end
    last_stb_a = sym_strobe_a;
    if (sym_strobe_a) stb_cnt_a++;
    sb_stb = sym_strobe_b;
    pre_b  = state_b;
    @(posedge clk);
    #1;
    cyc++;
    chk_dut("a", ma, pa, state_a, busy_a, done_a, sym_bit_a, y_n_a);
    chk_dut("b", mb, pbp, state_b, busy_b, done_b, sym_bit_b, y_n_b);
    if (collect && pre_b == 2'd2 && sb_stb) bq.push_back(int'(sym_bit_b));
    if ($signed(y_n_b) == 8'sd127) saw_hi = 1'b1;
    if ($signed(y_n_b) == -8'sd128) saw_lo = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vec_t       tbl[25];
    int         pay_y[8];
    bit         pay_b[8];
    bit         exp7[7];
    bit [6:0]   l;
    bit         ok;
    int         t_start, gap_tot, ones, per, s0, tr;
    longint     f, want;
    int         trims[2];

    pa  = '{FCW_A, 16, 64, 16};
    pbp = '{FCW_B, 4, 120, 60};
    l = 7'h7F;
    for (int k = 0; k < 127; k++) begin
      prbs[k] = l[6] ^ l[5];
      l = {l[5:0], prbs[k]};
    end

    // Nominal burst, len=8: preamble alternates, payload PRBS from the 7F seed.
    pay_y = '{-80, -80, -80, -80, -80, -80, 48, -48};
    pay_b = '{0, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b0, (i == 5) ? 37 : 0, (i == 0) ? 64 : ((i % 2 == 0) ? 48 : -48),
                 (i % 2 == 0), (i == 15) ? 2 : 1, 1'b0};
    for (int i = 0; i < 8; i++) tbl[16 + i] = '{1'b0, 0, pay_y[i], pay_b[i], 2, 1'b0};
    tbl[24] = '{1'b1, 0, 0, 1'b0, 0, 1'b1};
    exp7 = '{0, 0, 0, 0, 0, 0, 1};
    trims = '{1000, -1000};

    rst = 1'b1; en = 1'b1; start = 1'b0; fcw_trim = '0; payload_len = 16'd8;
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_state", int'(state_a), 0);
    chk("reset_y_n", int'(y_n_a), 0);
    chk("reset_busy", int'(busy_a), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    t_start = cyc;
    gap_tot = 0;
    for (int i = 0; i < 25; i++) begin
      if (tbl[i].gap > 0) begin
        en = 1'b0;
        repeat (tbl[i].gap) tick();
        en = 1'b1;
        gap_tot += tbl[i].gap;
      end
      start = tbl[i].start;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
        tick();
        if (last_stb_a) begin
          ok = 1'b1;
          break;
        end
      end
      start = 1'b0;
      chk($sformatf("vec%0d_strobe_seen", i), int'(ok), 1);
      want = ((longint'(i + 1) * longint'(TWO32)) + longint'(FCW_A) - 1) / longint'(FCW_A);
      chk($sformatf("vec%0d_strobe_cycle", i), cyc - t_start - gap_tot, int'(want));
      chk($sformatf("vec%0d_y_n", i), int'($signed(y_n_a)), tbl[i].y);
      chk($sformatf("vec%0d_sym_bit", i), int'(sym_bit_a), int'(tbl[i].b));
      chk($sformatf("vec%0d_state", i), int'(state_a), tbl[i].st);
      chk($sformatf("vec%0d_done", i), int'(done_a), int'(tbl[i].dn));
    end
    tick();
    chk("done_one_cycle", int'(done_a), 0);
    chk("idle_after_done", int'(state_a), 0);

    // Continuous payload on the fast instance: PRBS7 period and balance, saturation.
    rst = 1'b1; tick(); rst = 1'b0;
    payload_len = '0;
    start = 1'b1; tick(); start = 1'b0;
    bq.delete();
    collect = 1'b1;
    for (int k = 0; k < 2000 && bq.size() < 254; k++) tick();
    chk("prbs_collected", int'(bq.size() >= 254), 1);
    if (bq.size() >= 254) begin
      ones = 0; per = 0;
      for (int i = 0; i < 127; i++) begin
        ones += bq[i];
        if (bq[i] != bq[i + 127]) per++;
      end
      chk("prbs_ones", ones, 64);
      chk("prbs_period", per, 0);
    end
    chk("b_still_busy", int'(busy_b), 1);
    chk("b_saturate_hi", int'(saw_hi), 1);
    chk("b_saturate_lo", int'(saw_lo), 1);

    // Reset mid-payload aborts silently; the next burst restarts the PRBS.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_abort_done", int'(done_b), 0);
    chk("rst_abort_state", int'(state_b), 0);
    bq.delete();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 200 && bq.size() < 7; k++) tick();
    chk("restart_collected", int'(bq.size() >= 7), 1);
    if (bq.size() >= 7)
      for (int i = 0; i < 7; i++) chk($sformatf("restart_bit%0d", i), bq[i], int'(exp7[i]));
    collect = 1'b0;

    // Long-run strobe count with trimmed FCW matches floor(N*fcw/2^32).
    for (int j = 0; j < 2; j++) begin
      tr = trims[j];
      rst = 1'b1; tick(); rst = 1'b0;
      fcw_trim = 16'(tr);
      payload_len = '0;
      start = 1'b1; tick(); start = 1'b0;
      s0 = stb_cnt_a;
      repeat (25000) tick();
      f = longint'(FCW_A) + longint'(tr);
      want = (longint'(25000) * f) / longint'(TWO32);
      chk($sformatf("trim%0d_strobe_count", tr), stb_cnt_a - s0, int'(want));
    end

    // Randomized traffic: enables, starts, trims, lengths and rare resets.
    fcw_trim = '0;
    for (int k = 0; k < 12000; k++) begin
      rst   = ($urandom_range(2999) == 0);
      en    = ($urandom_range(9) != 0);
      start = ($urandom_range(49) == 0);
      if ($urandom_range(499) == 0) fcw_trim = 16'($signed($urandom_range(6000)) - 3000);
      payload_len = ($urandom_range(15) == 0) ? 16'd0 : 16'($urandom_range(6, 1));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
